// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer for the 5-stage MIPS core: RAW stalls, branch flushes, memory-wait freeze
// with a timeout watchdog, and saturating stall/flush/wait performance counters.
module hazard_stall_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fwd_en,
  input  logic             id_valid,
  input  logic [4:0]       id_src1,
  input  logic [4:0]       id_src2,
  input  logic             id_two_src,
  input  logic [4:0]       exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [4:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic             br_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             clr_cnt,
  output logic             freeze_front,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             freeze_all,
  output logic             err,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam int TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_t          cur_state, next_state;
  logic [TW-1:0]   timer, timer_next;
  logic            raw_exe, raw_mem, hazard, mem_busy;
  logic            run_rules, stall_inc, flush_inc, wait_inc;

  assign raw_exe  = exe_wb_en && (exe_dest != 5'd0) &&
                    ((id_src1 == exe_dest) || (id_two_src && (id_src2 == exe_dest)));
  assign raw_mem  = mem_wb_en && (mem_dest != 5'd0) &&
                    ((id_src1 == mem_dest) || (id_two_src && (id_src2 == mem_dest)));
  // With forwarding only a load in EXE cannot be bypassed in time.
  assign hazard   = id_valid && (fwd_en ? (raw_exe && exe_mem_r_en) : (raw_exe || raw_mem));
  assign mem_busy = mem_req && !mem_ready;

  assign err   = (cur_state == ERROR);
  assign state = cur_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state <= RUN;
      timer     <= '0;
    end else begin
      cur_state <= next_state;
      timer     <= timer_next;
    end
  end

  always_comb begin
    next_state   = cur_state;
    timer_next   = timer;
    freeze_all   = 1'b0;
    freeze_front = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    run_rules    = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    wait_inc     = 1'b0;
    case (cur_state)
      RUN: begin
        if (mem_busy) begin
          freeze_all = 1'b1;
          wait_inc   = 1'b1;
          next_state = MEM_WAIT;
          timer_next = TW'(1);
        end else begin
          run_rules = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (mem_busy) begin
          freeze_all = 1'b1;
          wait_inc   = 1'b1;
          if (timer == TW'(MEM_TIMEOUT)) next_state = ERROR;
          else                           timer_next = timer + 1'b1;
        end else begin
          // The access completes this cycle, so the normal pipe rules already apply.
          run_rules  = 1'b1;
          next_state = RUN;
          timer_next = '0;
        end
      end
      ERROR: begin
        freeze_all = 1'b1;
      end
      default: begin
        next_state = RUN;
        timer_next = '0;
      end
    endcase
    if (run_rules) begin
      if (br_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        flush_inc  = 1'b1;
      end else if (hazard) begin
        freeze_front = 1'b1;
        idex_flush   = 1'b1;
        stall_inc    = 1'b1;
      end
    end
  end

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c, input logic inc);
    return (inc && (c != {CNT_W{1'b1}})) ? c + 1'b1 : c;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      wait_cnt  <= '0;
    end else if (clr_cnt) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      stall_cnt <= bump(stall_cnt, stall_inc);
      flush_cnt <= bump(flush_cnt, flush_inc);
      wait_cnt  <= bump(wait_cnt, wait_inc);
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl (MEM_TIMEOUT=4, CNT_W=4) with hand-computed expectations.
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       fwd_en, id_valid, id_two_src, exe_wb_en, exe_mem_r_en, mem_wb_en;
  logic [4:0] id_src1, id_src2, exe_dest, mem_dest;
  logic       br_taken, mem_req, mem_ready, clr_cnt;
  logic       freeze_front, ifid_flush, idex_flush, freeze_all, err;
  logic [1:0] state;
  logic [3:0] stall_cnt, flush_cnt, wait_cnt;

  int check_count = 0;
  int pass_count  = 0;

  hazard_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .fwd_en(fwd_en), .id_valid(id_valid),
    .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .br_taken(br_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .clr_cnt(clr_cnt),
    .freeze_front(freeze_front), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .freeze_all(freeze_all), .err(err), .state(state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  task automatic applyStimulus();
    fwd_en = 0; id_valid = 0; id_src1 = 0; id_src2 = 0; id_two_src = 0;
    exe_dest = 0; exe_wb_en = 0; exe_mem_r_en = 0; mem_dest = 0; mem_wb_en = 0;
    br_taken = 0; mem_req = 0; mem_ready = 0; clr_cnt = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkCtl(input string tag, input logic ff, input logic ifl, input logic idl, input logic fa);
    #1;
    checkOutput({tag, ".freeze_front"}, 32'(freeze_front), 32'(ff));
    checkOutput({tag, ".ifid_flush"},   32'(ifid_flush),   32'(ifl));
    checkOutput({tag, ".idex_flush"},   32'(idex_flush),   32'(idl));
    checkOutput({tag, ".freeze_all"},   32'(freeze_all),   32'(fa));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus();
    rst = 1'b1;
    #12;
    checkCtl("reset", 0, 0, 0, 0);
    checkOutput("reset.state", 32'(state), 0);
    checkOutput("reset.err", 32'(err), 0);
    checkOutput("reset.counters", {20'd0, stall_cnt, flush_cnt, wait_cnt}, 0);
    rst = 1'b0;
    tick(1);

    // 1: RAW on EXE without forwarding, then dest=0, then RAW on MEM
    exe_wb_en = 1; exe_dest = 5; id_src1 = 5; id_valid = 1;
    checkCtl("t1_raw_exe", 1, 0, 1, 0);
    tick(1);
    checkOutput("t1.stall_cnt", 32'(stall_cnt), 1);
    exe_dest = 0;
    checkCtl("t1_dest0", 0, 0, 0, 0);
    tick(1);
    checkOutput("t1_dest0.stall_cnt", 32'(stall_cnt), 1);
    exe_wb_en = 0; mem_wb_en = 1; mem_dest = 5;
    checkCtl("t1_raw_mem", 1, 0, 1, 0);
    tick(1);
    checkOutput("t1_raw_mem.stall_cnt", 32'(stall_cnt), 2);

    // 2: forwarding active, only load-use stalls
    applyStimulus();
    fwd_en = 1; id_valid = 1; exe_wb_en = 1; exe_mem_r_en = 1; exe_dest = 7;
    id_src1 = 3; id_src2 = 7; id_two_src = 1;
    checkCtl("t2_load_use", 1, 0, 1, 0);
    tick(1);
    checkOutput("t2.stall_cnt", 32'(stall_cnt), 3);
    id_two_src = 0;
    checkCtl("t2_one_src", 0, 0, 0, 0);
    id_two_src = 1; exe_wb_en = 0; exe_mem_r_en = 0; mem_wb_en = 1; mem_dest = 7;
    checkCtl("t2_mem_fwd", 0, 0, 0, 0);
    tick(1);
    checkOutput("t2_nostall.stall_cnt", 32'(stall_cnt), 3);

    // 3: branch beats hazard
    applyStimulus();
    id_valid = 1; exe_wb_en = 1; exe_dest = 9; id_src1 = 9; br_taken = 1;
    checkCtl("t3_branch", 0, 1, 1, 0);
    tick(1);
    checkOutput("t3.flush_cnt", 32'(flush_cnt), 1);
    checkOutput("t3.stall_cnt", 32'(stall_cnt), 3);

    // 4: memory busy for 3 cycles, hazard masked, branch on the ready cycle
    br_taken = 0; mem_req = 1;
    checkCtl("t4_enter", 0, 0, 0, 1);
    checkOutput("t4_enter.state", 32'(state), 0);
    tick(1);
    checkOutput("t4_c1.state", 32'(state), 1);
    checkOutput("t4_c1.stall_cnt", 32'(stall_cnt), 3);
    checkCtl("t4_c2", 0, 0, 0, 1);
    tick(2);
    mem_ready = 1; br_taken = 1;
    checkCtl("t4_ready", 0, 1, 1, 0);
    tick(1);
    checkOutput("t4.state", 32'(state), 0);
    checkOutput("t4.wait_cnt", 32'(wait_cnt), 3);
    checkOutput("t4.flush_cnt", 32'(flush_cnt), 2);

    // 5: timeout into ERROR, then async reset mid-cycle
    applyStimulus();
    mem_req = 1;
    tick(4);
    checkOutput("t5_c4.state", 32'(state), 1);
    tick(1);
    checkOutput("t5.state", 32'(state), 2);
    checkOutput("t5.err", 32'(err), 1);
    checkOutput("t5.wait_cnt", 32'(wait_cnt), 8);
    mem_ready = 1; br_taken = 1;
    checkCtl("t5_error", 0, 0, 0, 1);
    tick(2);
    checkOutput("t5_held.state", 32'(state), 2);
    checkOutput("t5_held.err", 32'(err), 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("t5_rst.state", 32'(state), 0);
    checkOutput("t5_rst.err", 32'(err), 0);
    checkOutput("t5_rst.counters", {20'd0, stall_cnt, flush_cnt, wait_cnt}, 0);
    applyStimulus();
    tick(1);
    rst = 1'b0;

    // 6: saturation at 15, then clear with a concurrent hazard
    id_valid = 1; exe_wb_en = 1; exe_dest = 5; id_src1 = 5;
    tick(20);
    checkOutput("t6_sat.stall_cnt", 32'(stall_cnt), 15);
    clr_cnt = 1;
    tick(1);
    checkOutput("t6_clr.stall_cnt", 32'(stall_cnt), 0);
    clr_cnt = 0;
    tick(1);
    checkOutput("t6_after.stall_cnt", 32'(stall_cnt), 1);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
